result_tx_sequencer: RTL and testbench

- Transmit-side counterpart to the matrix-receive path. Streams the N x N result matrix out through the UART transmitter byte by byte.
- On `start`, it reads 16-bit result elements from the result buffer in row-major order and splits each element into two bytes, MSB first.
- Each byte is handed to the UART TX using the tx_start/tx_busy handshake.
- It reports `busy` while streaming and pulses `done` when the last byte has completed.

---
 rtl/result_tx_sequencer_if.sv | 28 ++
 rtl/result_tx_sequencer.sv | 152 +++++++++++++++
 tb/tb_result_tx_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/result_tx_sequencer_if.sv
// Handshake and bus bundle between the result TX sequencer, the result buffer
// and the UART transmitter. master = sequencer side, slave = environment side.
interface result_tx_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [3:0]        matrix_size;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              busy;
    logic              done;
    logic [8:0]        byte_count;

    modport master (
        input  start, matrix_size, rd_data, tx_busy,
        output rd_en, rd_addr, tx_data, tx_start, busy, done, byte_count
    );

    modport slave (
        output start, matrix_size, rd_data, tx_busy,
        input  rd_en, rd_addr, tx_data, tx_start, busy, done, byte_count
    );
endinterface

// File: rtl/result_tx_sequencer.sv
// Streams the N x N result matrix to the UART TX, MSB byte first, row-major.
// Optional trailing XOR checksum byte when RESULT_TX_CHECKSUM_EN is defined.
module result_tx_sequencer #(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 3,
    parameter int ADDR_W = 4
) (
    input  logic clk,
    input  logic rst,
    result_tx_sequencer_if.master seq_if
);
    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, SEND_HI, ACK_HI, DRAIN_HI,
        SEND_LO, ACK_LO, DRAIN_LO, NEXT,
`ifdef RESULT_TX_CHECKSUM_EN
        CKSUM, ACK_CK, DRAIN_CK,
`endif
        FINISH
    } state_t;

    localparam logic [3:0] MAX_N_L = 4'(MAX_N);

    state_t            state_q;
    logic [7:0]        total_q;
    logic [7:0]        idx_q;
    logic [DATA_W-1:0] elem_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              busy_q;
    logic              done_q;
    logic [8:0]        byte_cnt_q;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]        cksum_q;
`endif

    logic [3:0] n_eff_d;
    logic [7:0] total_d;
    logic [7:0] send_byte_d;

    always_comb begin
        n_eff_d     = (seq_if.matrix_size > MAX_N_L) ? MAX_N_L : seq_if.matrix_size;
        total_d     = {4'd0, n_eff_d} * {4'd0, n_eff_d};
        send_byte_d = (state_q == SEND_HI) ? elem_q[DATA_W-1 -: 8] : elem_q[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            total_q    <= '0;
            idx_q      <= '0;
            elem_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: if (seq_if.start) begin
                    total_q    <= total_d;
                    idx_q      <= '0;
                    byte_cnt_q <= '0;
                    busy_q     <= 1'b1;
`ifdef RESULT_TX_CHECKSUM_EN
                    cksum_q    <= '0;
`endif
                    if (n_eff_d == 4'd0) begin
                        state_q <= FINISH;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    elem_q  <= seq_if.rd_data;
                    state_q <= SEND_HI;
                end
                SEND_HI, SEND_LO: if (!seq_if.tx_busy) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= send_byte_d;
`ifdef RESULT_TX_CHECKSUM_EN
                    cksum_q    <= cksum_q ^ send_byte_d;
`endif
                    state_q    <= (state_q == SEND_HI) ? ACK_HI : ACK_LO;
                end
                // The pulse cycle itself is skipped so a same-cycle busy rise is ignored.
                ACK_HI: if (!tx_start_q && seq_if.tx_busy) state_q <= DRAIN_HI;
                ACK_LO: if (!tx_start_q && seq_if.tx_busy) state_q <= DRAIN_LO;
                DRAIN_HI: if (!seq_if.tx_busy) begin
                    byte_cnt_q <= byte_cnt_q + 9'd1;
                    state_q    <= SEND_LO;
                end
                DRAIN_LO: if (!seq_if.tx_busy) begin
                    byte_cnt_q <= byte_cnt_q + 9'd1;
                    state_q    <= NEXT;
                end
                NEXT: begin
                    if (idx_q == total_q - 8'd1) begin
`ifdef RESULT_TX_CHECKSUM_EN
                        state_q <= CKSUM;
`else
                        state_q <= FINISH;
`endif
                    end else begin
                        idx_q     <= idx_q + 8'd1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ADDR_W'(idx_q + 8'd1);
                        state_q   <= FETCH;
                    end
                end
`ifdef RESULT_TX_CHECKSUM_EN
                CKSUM: if (!seq_if.tx_busy) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= cksum_q;
                    state_q    <= ACK_CK;
                end
                ACK_CK: if (!tx_start_q && seq_if.tx_busy) state_q <= DRAIN_CK;
                DRAIN_CK: if (!seq_if.tx_busy) begin
                    byte_cnt_q <= byte_cnt_q + 9'd1;
                    state_q    <= FINISH;
                end
`endif
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seq_if.rd_en      = rd_en_q;
    assign seq_if.rd_addr    = rd_addr_q;
    assign seq_if.tx_data    = tx_data_q;
    assign seq_if.tx_start   = tx_start_q;
    assign seq_if.busy       = busy_q;
    assign seq_if.done       = done_q;
    assign seq_if.byte_count = byte_cnt_q;
endmodule

// File: tb/tb_result_tx_sequencer.sv
// Randomized bench for result_tx_sequencer: buffer model, UART model with
// configurable busy length / late busy rise, and a queue-based byte reference.
module tb_result_tx_sequencer;
    localparam int DATA_W = 16;
    localparam int MAX_N  = 3;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_tx_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    result_tx_sequencer #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (bus)
    );

    logic [15:0] mem [0:15];
    logic [7:0]  cap_q [$];
    int          rd_log [$];
    logic [7:0]  exp_bytes [$];
    int          done_cnt   = 0;
    int          start_viol = 0;
    logic        uart_hold  = 1'b0;
    logic        busy_r     = 1'b0;
    int          dly        = 0;
    int          bcnt       = 0;
    int          busy_len   = 10;
    int          late       = 0;
    int          checks     = 0;
    int          fails      = 0;

    assign bus.tx_busy = uart_hold | busy_r;

    // UART transmitter model: records every byte, busy for busy_len cycles,
    // optionally raising busy `late` cycles after the start pulse.
    always @(posedge clk) begin
        if (bus.tx_start) begin
            if (bus.tx_busy) start_viol <= start_viol + 1;
            cap_q.push_back(bus.tx_data);
            if (late == 0) begin
                busy_r <= 1'b1;
                bcnt   <= busy_len;
            end else begin
                dly <= late;
            end
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                busy_r <= 1'b1;
                bcnt   <= busy_len;
            end
        end else if (busy_r) begin
            bcnt <= bcnt - 1;
            if (bcnt <= 1) busy_r <= 1'b0;
        end
    end

    // Result buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr];
            rd_log.push_back(int'(bus.rd_addr));
        end
    end

    always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_eff(input int msize);
        return (msize > MAX_N) ? MAX_N : msize;
    endfunction

    task automatic build_model(input int msize);
        logic [15:0] w;
        logic [7:0]  x;
        int          n;
        n = n_eff(msize);
        x = 8'h00;
        exp_bytes.delete();
        for (int i = 0; i < n * n; i++) begin
            w = mem[i];
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
`ifdef RESULT_TX_CHECKSUM_EN
        if (n > 0) exp_bytes.push_back(x);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        chk(tag, int'({bus.rd_en, bus.rd_addr, bus.tx_data, bus.tx_start,
                       bus.busy, bus.done, bus.byte_count}), 0);
    endtask

    task automatic run_xfer(input int msize, input int hold, input bit restart, output int cyc);
        int cb, rb, db, vb, n;
        bit sent;
        build_model(msize);
        n    = n_eff(msize);
        cb   = cap_q.size();
        rb   = rd_log.size();
        db   = done_cnt;
        vb   = start_viol;
        sent = 1'b0;
        @(negedge clk);
        uart_hold       = (hold > 0);
        bus.matrix_size = msize[3:0];
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        chk("busy_after_start", int'(bus.busy), 1);
        for (int i = 0; i < hold; i++) @(negedge clk);
        uart_hold = 1'b0;
        cyc += hold;
        while (done_cnt == db && cyc < 20000) begin
            if (restart && !sent && (cap_q.size() - cb) == 3) begin
                bus.start       = 1'b1;
                bus.matrix_size = 4'd3;
                sent            = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("done_seen", int'(done_cnt != db), 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - db, 1);
        chk("byte_total", cap_q.size() - cb, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && cb + i < cap_q.size(); i++)
            chk($sformatf("byte[%0d]", i), int'(cap_q[cb + i]), int'(exp_bytes[i]));
        chk("read_total", rd_log.size() - rb, n * n);
        for (int i = 0; i < n * n && rb + i < rd_log.size(); i++)
            chk($sformatf("rd_addr[%0d]", i), rd_log[rb + i], i);
        chk("byte_count", int'(bus.byte_count), exp_bytes.size());
        chk("busy_end", int'(bus.busy), 0);
        chk("start_while_busy", start_viol - vb, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int cyc, cb, wait_cnt;
        bus.start       = 1'b0;
        bus.matrix_size = 4'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;

        // Basic stream with 0x0102, 0x0304, ... contents.
        for (int i = 0; i < 16; i++) mem[i] = {8'(2 * i + 1), 8'(2 * i + 2)};
        busy_len = 10; late = 0;
        run_xfer(3, 0, 1'b0, cyc);

        // Zero size.
        run_xfer(0, 0, 1'b0, cyc);
        chk("zero_latency_ok", int'(cyc <= 3), 1);

        // Clamp to MAX_N.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        run_xfer(5, 0, 1'b0, cyc);

        // Backpressure: held busy before first byte plus late busy rise.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        late = 3;
        run_xfer(3, 50, 1'b0, cyc);
        late = 0;

        // Reset mid-transfer after the fifth byte, then a clean N=2 transfer.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        cb = cap_q.size();
        @(negedge clk);
        bus.matrix_size = 4'd2;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cnt = 0;
        while ((cap_q.size() - cb) < 5 && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("reach_byte5", int'((cap_q.size() - cb) >= 5), 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_midxfer");
        @(negedge clk);
        check_outputs_zero("reset_held");
        rst = 1'b0;
        wait_cnt = 0;
        while (bus.tx_busy && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("uart_idle", int'(bus.tx_busy), 0);
        run_xfer(2, 0, 1'b0, cyc);

        // Start pulse while busy is ignored.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        run_xfer(2, 0, 1'b1, cyc);

        // Randomized transfers.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            busy_len = $urandom_range(1, 12);
            late     = $urandom_range(0, 3);
            run_xfer($urandom_range(0, 15), $urandom_range(0, 1) * $urandom_range(1, 20),
                     1'($urandom_range(0, 1)), cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
